// File: rtl/aes_pkg.sv
// Shared AES types, mode encodings, size lookups and round constants.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ks_state_e;

  localparam logic [1:0] AES_128 = 2'd0;
  localparam logic [1:0] AES_192 = 2'd1;
  localparam logic [1:0] AES_256 = 2'd2;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      AES_192: return 4'd6;
      AES_256: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      AES_192: return 4'd12;
      AES_256: return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inv accumulates x^2 * x^4 * ... * x^128 = x^254, which maps 0 to 0
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock, registered round-key read port.
// Optional macro AES_KS_DEC_ORDER_EN adds rk_rev for reversed (decryption-order) round-key indexing.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    keys_valid,
  output logic                    err,
  output logic [3:0]              nr,
`ifdef AES_KS_DEC_ORDER_EN
  input  logic                    rk_rev,
`endif
  input  logic [3:0]              rk_idx,
  output logic [127:0]            rk_out
);

  localparam int unsigned NR_MAX    = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
  localparam int unsigned NW_MAX    = 4 * (NR_MAX + 1);
  localparam int unsigned KEY_WORDS = MAX_KEY_BITS / 32;

  word_t     w_q [NW_MAX];
  ks_state_e state_q, state_d;
  logic [5:0] i_q, i_d;
  logic [2:0] pos_q, pos_d;
  logic [3:0] rc_q, rc_d;
  logic [3:0] nk_q, nk_d;
  logic [3:0] nr_run_q, nr_run_d;
  logic [3:0] nr_q, nr_d;
  logic       kv_q, kv_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  rkey_t      rk_q, rk_d;

  logic       mode_legal, accept, reject, last;
  word_t      prev_w, back_w, rot_w, sub_in, sub_out, temp_w, new_w;
  logic [3:0] rd_k;
  logic [5:0] rd_base;

  for (genvar b = 0; b < 4; b++) begin : gen_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    case (mode)
      AES_128: mode_legal = 1'b1;
      AES_192: mode_legal = (MAX_KEY_BITS >= 192);
      AES_256: mode_legal = (MAX_KEY_BITS >= 256);
      default: mode_legal = 1'b0;
    endcase
    accept = start && (state_q != RUN) && mode_legal;
    reject = start && (state_q != RUN) && !mode_legal;
    last   = (state_q == RUN) && (i_q == ({nr_run_q, 2'b00} + 6'd3));
  end

  // pos_q tracks i mod Nk and rc_q tracks i/Nk - 1, so no divider is needed
  always_comb begin
    prev_w = w_q[i_q - 6'd1];
    back_w = w_q[i_q - {2'b00, nk_q}];
    rot_w  = {prev_w[7:0], prev_w[31:8]};
    sub_in = (pos_q == 3'd0) ? rot_w : prev_w;
    if (pos_q == 3'd0)
      temp_w = sub_out ^ {24'h000000, RCON[rc_q]};
    else if (nk_q == 4'd8 && pos_q == 3'd4)
      temp_w = sub_out;
    else
      temp_w = prev_w;
    new_w = back_w ^ temp_w;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (accept) state_d = RUN;
      RUN:        if (last)   state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == RUN);
    done       = done_q;
    keys_valid = kv_q;
    err        = err_q;
    nr         = nr_q;
    rk_out     = rk_q;
  end

  always_comb begin
    i_d      = i_q;
    pos_d    = pos_q;
    rc_d     = rc_q;
    nk_d     = nk_q;
    nr_run_d = nr_run_q;
    nr_d     = nr_q;
    kv_d     = kv_q;
    done_d   = 1'b0;
    err_d    = reject;
    if (accept) begin
      nk_d     = nk_of(mode);
      nr_run_d = nr_of(mode);
      i_d      = {2'b00, nk_of(mode)};
      pos_d    = '0;
      rc_d     = '0;
      kv_d     = 1'b0;
    end else if (state_q == RUN) begin
      i_d   = i_q + 6'd1;
      pos_d = ({1'b0, pos_q} == nk_q - 4'd1) ? 3'd0 : pos_q + 3'd1;
      rc_d  = (pos_q == 3'd0) ? rc_q + 4'd1 : rc_q;
      if (last) begin
        done_d = 1'b1;
        kv_d   = 1'b1;
        nr_d   = nr_run_q;
      end
    end
  end

  always_comb begin
`ifdef AES_KS_DEC_ORDER_EN
    rd_k = rk_rev ? nr_q - rk_idx : rk_idx;
`else
    rd_k = rk_idx;
`endif
    rd_base = {rd_k, 2'b00};
    rk_d    = '0;
    if (kv_q && rk_idx <= nr_q)
      rk_d = {w_q[rd_base + 6'd3], w_q[rd_base + 6'd2], w_q[rd_base + 6'd1], w_q[rd_base]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      pos_q    <= '0;
      rc_q     <= '0;
      nk_q     <= '0;
      nr_run_q <= '0;
      nr_q     <= '0;
      kv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rk_q     <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      pos_q    <= pos_d;
      rc_q     <= rc_d;
      nk_q     <= nk_d;
      nr_run_q <= nr_run_d;
      nr_q     <= nr_d;
      kv_q     <= kv_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rk_q     <= rk_d;
    end
  end

  // Schedule storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned j = 0; j < KEY_WORDS; j++)
        if (j < 32'(nk_of(mode))) w_q[j[5:0]] <= key_in[32*j +: 32];
    end else if (state_q == RUN) begin
      w_q[i_q] <= new_w;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed self-checking bench for aes_key_expander using FIPS-197 Appendix A vectors.
module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, start2;
  logic [1:0]   mode, mode2;
  logic [255:0] key_in;
  logic [127:0] key2;
  logic [3:0]   rk_idx, rk_idx2;
  logic         busy, done, kv, err, busy2, done2, kv2, err2;
  logic [3:0]   nr, nr2;
  logic [127:0] rk_out, rk_out2;
`ifdef AES_KS_DEC_ORDER_EN
  logic         rk_rev, rk_rev2;
`endif

  int tests = 0;
  int fails = 0;

  aes_key_expander #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(kv), .err(err), .nr(nr),
`ifdef AES_KS_DEC_ORDER_EN
    .rk_rev(rk_rev),
`endif
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  aes_key_expander #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .key_in(key2),
    .busy(busy2), .done(done2), .keys_valid(kv2), .err(err2), .nr(nr2),
`ifdef AES_KS_DEC_ORDER_EN
    .rk_rev(rk_rev2),
`endif
    .rk_idx(rk_idx2), .rk_out(rk_out2)
  );

  // Hex literals are written in FIPS byte order (byte 0 leftmost); the DUT wants byte 0 at [7:0].
  function automatic logic [255:0] key_of(input logic [255:0] x, input int n);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = x[8*(n-1-k) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rk_of(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x[8*(15-k) +: 8];
    return r;
  endfunction

  logic [255:0] k128, k192, k256;
  logic [127:0] e128_0, e128_1, e128_9, e128_10, e192_12, e256_0, e256_1, e256_14;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_exp(input logic [1:0] m, input logic [255:0] k, output int lat);
    mode = m; key_in = k; start = 1'b1; lat = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      start = 1'b0;
      lat++;
      if (done) break;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
    rk_idx = idx;
    tick();
    v = rk_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests++; if ({busy, done, kv, err, nr} !== 8'h00) begin fails++;
      $display("FAIL reset_flags: got %h expected 00", {busy, done, kv, err, nr}); end
    tests++; if (rk_out !== 128'h0) begin fails++;
      $display("FAIL reset_rk_out: got %h expected 0", rk_out); end
    tests++; if ({busy2, done2, kv2, err2, nr2, rk_out2} !== 136'h0) begin fails++;
      $display("FAIL reset_dut128: got %h expected 0", {busy2, done2, kv2, err2, nr2, rk_out2}); end
    rst = 1'b0;
  endtask

  task automatic test_aes128();
    int lat;
    logic [127:0] v;
    run_exp(2'd0, k128, lat);
    tests++; if (lat !== 41) begin fails++; $display("FAIL aes128_latency: got %0d expected 41", lat); end
    tests++; if (nr !== 4'd10) begin fails++; $display("FAIL aes128_nr: got %0d expected 10", nr); end
    tests++; if ({kv, busy} !== 2'b10) begin fails++;
      $display("FAIL aes128_kv_busy: got %b expected 10", {kv, busy}); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL aes128_done_pulse: got %b expected 0", done); end
    read_rk(4'd10, v);
    tests++; if (v !== e128_10) begin fails++; $display("FAIL aes128_rk10: got %h expected %h", v, e128_10); end
    read_rk(4'd0, v);
    tests++; if (v !== e128_0) begin fails++; $display("FAIL aes128_rk0: got %h expected %h", v, e128_0); end
    read_rk(4'd1, v);
    tests++; if (v !== e128_1) begin fails++; $display("FAIL aes128_rk1: got %h expected %h", v, e128_1); end
    read_rk(4'd11, v);
    tests++; if (v !== 128'h0) begin fails++; $display("FAIL aes128_rk11_range: got %h expected 0", v); end
    read_rk(4'd15, v);
    tests++; if (v !== 128'h0) begin fails++; $display("FAIL aes128_rk15_range: got %h expected 0", v); end
  endtask

  task automatic test_illegal();
    int lat;
    mode = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if ({err, busy, kv, nr} !== 7'b1_0_1_1010) begin fails++;
      $display("FAIL mode3_err: got %b expected 1011010", {err, busy, kv, nr}); end
    tick();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL mode3_err_pulse: got %b expected 0", err); end
    mode2 = 2'd2; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tests++; if ({err2, busy2} !== 2'b10) begin fails++;
      $display("FAIL max128_mode2_err: got %b expected 10", {err2, busy2}); end
    mode2 = 2'd1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tests++; if ({err2, busy2} !== 2'b10) begin fails++;
      $display("FAIL max128_mode1_err: got %b expected 10", {err2, busy2}); end
    tick();
    tests++; if (err2 !== 1'b0) begin fails++; $display("FAIL max128_err_pulse: got %b expected 0", err2); end
    mode2 = 2'd0; key2 = k128[127:0]; start2 = 1'b1; lat = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      start2 = 1'b0;
      lat++;
      if (done2) break;
    end
    tests++; if (lat !== 41) begin fails++; $display("FAIL max128_latency: got %0d expected 41", lat); end
    rk_idx2 = 4'd10;
    tick();
    tests++; if (rk_out2 !== e128_10) begin fails++;
      $display("FAIL max128_rk10: got %h expected %h", rk_out2, e128_10); end
  endtask

  task automatic test_aes192();
    int lat;
    logic [127:0] v;
    run_exp(2'd1, k192, lat);
    tests++; if (lat !== 47) begin fails++; $display("FAIL aes192_latency: got %0d expected 47", lat); end
    tests++; if (nr !== 4'd12) begin fails++; $display("FAIL aes192_nr: got %0d expected 12", nr); end
    read_rk(4'd12, v);
    tests++; if (v !== e192_12) begin fails++; $display("FAIL aes192_rk12: got %h expected %h", v, e192_12); end
    read_rk(4'd13, v);
    tests++; if (v !== 128'h0) begin fails++; $display("FAIL aes192_rk13_range: got %h expected 0", v); end
  endtask

  task automatic test_aes256();
    int lat;
    logic [127:0] v;
    run_exp(2'd2, k256, lat);
    tests++; if (lat !== 53) begin fails++; $display("FAIL aes256_latency: got %0d expected 53", lat); end
    tests++; if (nr !== 4'd14) begin fails++; $display("FAIL aes256_nr: got %0d expected 14", nr); end
    read_rk(4'd14, v);
    tests++; if (v !== e256_14) begin fails++; $display("FAIL aes256_rk14: got %h expected %h", v, e256_14); end
    read_rk(4'd0, v);
    tests++; if (v !== e256_0) begin fails++; $display("FAIL aes256_rk0: got %h expected %h", v, e256_0); end
    read_rk(4'd1, v);
    tests++; if (v !== e256_1) begin fails++; $display("FAIL aes256_rk1: got %h expected %h", v, e256_1); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [127:0] v;
    mode = 2'd2; key_in = k256; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    #1;
    tests++; if ({busy, done, kv, err, nr} !== 8'h00) begin fails++;
      $display("FAIL midrun_reset_flags: got %h expected 00", {busy, done, kv, err, nr}); end
    tests++; if (rk_out !== 128'h0) begin fails++;
      $display("FAIL midrun_reset_rk_out: got %h expected 0", rk_out); end
    @(negedge clk);
    rst = 1'b0;
    run_exp(2'd0, k128, lat);
    tests++; if (lat !== 41) begin fails++; $display("FAIL after_reset_latency: got %0d expected 41", lat); end
    read_rk(4'd10, v);
    tests++; if (v !== e128_10) begin fails++; $display("FAIL after_reset_rk10: got %h expected %h", v, e128_10); end
  endtask

  task automatic test_start_during_run();
    int lat;
    logic err_seen;
    logic [127:0] v;
    mode = 2'd0; key_in = k128; start = 1'b1; lat = 0; err_seen = 1'b0;
    for (int c = 0; c < 120; c++) begin
      tick();
      lat++;
      err_seen = err_seen | err;
      if (done) break;
      start = (lat == 5 || lat == 17 || lat == 30);
      mode  = start ? 2'd3 : 2'd0;
    end
    start = 1'b0; mode = 2'd0;
    tests++; if (lat !== 41) begin fails++; $display("FAIL busy_start_latency: got %0d expected 41", lat); end
    tests++; if (err_seen !== 1'b0) begin fails++; $display("FAIL busy_start_err: got %b expected 0", err_seen); end
    read_rk(4'd10, v);
    tests++; if (v !== e128_10) begin fails++; $display("FAIL busy_start_rk10: got %h expected %h", v, e128_10); end
  endtask

  task automatic test_restart();
    int lat;
    logic [127:0] v;
    mode = 2'd2; key_in = k256; start = 1'b1; lat = 0;
    tick();
    start = 1'b0;
    lat++;
    tests++; if ({kv, busy} !== 2'b01) begin fails++;
      $display("FAIL restart_kv_drop: got %b expected 01", {kv, busy}); end
    for (int c = 0; c < 120; c++) begin
      tick();
      lat++;
      if (done) break;
    end
    tests++; if (lat !== 53) begin fails++; $display("FAIL restart_latency: got %0d expected 53", lat); end
    tests++; if (kv !== 1'b1) begin fails++; $display("FAIL restart_kv: got %b expected 1", kv); end
    read_rk(4'd14, v);
    tests++; if (v !== e256_14) begin fails++; $display("FAIL restart_rk14: got %h expected %h", v, e256_14); end
  endtask

`ifdef AES_KS_DEC_ORDER_EN
  task automatic test_rev_order();
    int lat;
    logic [127:0] v;
    run_exp(2'd0, k128, lat);
    rk_rev = 1'b1;
    read_rk(4'd0, v);
    tests++; if (v !== e128_10) begin fails++; $display("FAIL rev_rk0: got %h expected %h", v, e128_10); end
    read_rk(4'd1, v);
    tests++; if (v !== e128_9) begin fails++; $display("FAIL rev_rk1: got %h expected %h", v, e128_9); end
    read_rk(4'd10, v);
    tests++; if (v !== e128_0) begin fails++; $display("FAIL rev_rk10: got %h expected %h", v, e128_0); end
    read_rk(4'd11, v);
    tests++; if (v !== 128'h0) begin fails++; $display("FAIL rev_rk11_range: got %h expected 0", v); end
    rk_rev = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = '0; mode2 = '0;
    key_in = '0; key2 = '0; rk_idx = '0; rk_idx2 = '0;
`ifdef AES_KS_DEC_ORDER_EN
    rk_rev = 1'b0; rk_rev2 = 1'b0;
`endif
    k128    = key_of(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
    k192    = key_of(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24);
    k256    = key_of(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32);
    e128_0  = rk_of(128'h2b7e151628aed2a6abf7158809cf4f3c);
    e128_1  = rk_of(128'ha0fafe1788542cb123a339392a6c7605);
    e128_9  = rk_of(128'head27321b58dbad2312bf5607f8d292f);
    e128_10 = rk_of(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    e192_12 = rk_of(128'he98ba06f448c773c8ecc720401002202);
    e256_0  = rk_of(128'h603deb1015ca71be2b73aef0857d7781);
    e256_1  = rk_of(128'h1f352c073b6108d72d9810a30914dff4);
    e256_14 = rk_of(128'hfe4890d1e6188d0b046df344706c631e);

    test_reset();
    test_aes128();
    test_illegal();
    test_aes192();
    test_aes256();
    test_reset_mid_run();
    test_start_during_run();
    test_restart();
`ifdef AES_KS_DEC_ORDER_EN
    test_rev_order();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
